// File: rtl/csr_unit.sv
// csr_unit: SYSTEM CSR decode, the tohost register and the 64-bit cycle/instret
// counters. The old CSR value is returned one cycle after the request.
module csr_unit #(
    parameter logic [11:0] TOHOST_ADDR  = 12'h51E,
    parameter logic [31:0] RESET_TOHOST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req,
    input  logic        csr_kill,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_rs1_data,
    input  logic [4:0]  csr_rs1_idx,
    input  logic        retire,
    output logic [31:0] csr_rdata,
    output logic        csr_rdata_valid,
    output logic        csr_illegal,
    output logic [31:0] tohost,
    output logic        tohost_wr
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 64;

    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    logic            f3_legal;
    logic            wr_intent;
    logic            addr_known;
    logic            addr_ro;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            req_ok;
    logic            rd_fire;
    logic            illegal_c;
    logic            tohost_we;

    // Decode the request: operand, old value, new value and the legality checks.
    always_comb begin
        f3_legal   = (csr_funct3[1:0] != 2'b00);
        src        = csr_funct3[2] ? XLEN'(csr_rs1_idx) : csr_rs1_data;
        // Set/clear with x0 or zimm=0 is a pure read.
        wr_intent  = f3_legal & ((csr_funct3[1:0] == 2'b01) | (csr_rs1_idx != 5'd0));
        old_val    = '0;
        addr_known = 1'b1;
        addr_ro    = 1'b0;
        case (csr_addr)
            TOHOST_ADDR:   old_val = tohost;
            ADDR_CYCLE:    begin old_val = cycle_q[31:0];    addr_ro = 1'b1; end
            ADDR_CYCLEH:   begin old_val = cycle_q[63:32];   addr_ro = 1'b1; end
            ADDR_INSTRET:  begin old_val = instret_q[31:0];  addr_ro = 1'b1; end
            ADDR_INSTRETH: begin old_val = instret_q[63:32]; addr_ro = 1'b1; end
            default:       addr_known = 1'b0;
        endcase
        case (csr_funct3[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
        req_ok    = csr_req & ~csr_kill;
        rd_fire   = req_ok & f3_legal;
        illegal_c = req_ok & (~f3_legal | ~addr_known | (addr_ro & wr_intent));
        tohost_we = req_ok & wr_intent & (csr_addr == TOHOST_ADDR);
    end

    // Free-running cycle counter and retire counter; both wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_q + CNT_W'(1);
            instret_q <= instret_q + CNT_W'(retire);
        end
    end

    // tohost register, its write pulse and the registered read response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tohost          <= RESET_TOHOST;
            tohost_wr       <= 1'b0;
            csr_rdata       <= '0;
            csr_rdata_valid <= 1'b0;
            csr_illegal     <= 1'b0;
        end else begin
            if (tohost_we) begin
                tohost <= new_val;
            end
            tohost_wr       <= tohost_we;
            csr_rdata       <= rd_fire ? old_val : '0;
            csr_rdata_valid <= rd_fire;
            csr_illegal     <= illegal_c;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed scenarios plus randomized traffic against a reference model.
module tb_csr_unit;

    localparam logic [11:0] TOHOST = 12'h51E;

    logic        clk;
    logic        rst;
    logic        csr_req;
    logic        csr_kill;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_rs1_data;
    logic [4:0]  csr_rs1_idx;
    logic        retire;
    logic [31:0] csr_rdata;
    logic        csr_rdata_valid;
    logic        csr_illegal;
    logic [31:0] tohost;
    logic        tohost_wr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural counters and tohost.
    longint unsigned m_cycle;
    longint unsigned m_instret;
    logic [31:0]     m_tohost;

    // Expected outputs after the most recent drive() edge.
    logic [31:0] e_rdata;
    logic        e_valid;
    logic        e_illegal;
    logic        e_wr;

    csr_unit #(.TOHOST_ADDR(TOHOST), .RESET_TOHOST(32'h0)) dut (
        .clk(clk), .rst(rst), .csr_req(csr_req), .csr_kill(csr_kill),
        .csr_funct3(csr_funct3), .csr_addr(csr_addr), .csr_rs1_data(csr_rs1_data),
        .csr_rs1_idx(csr_rs1_idx), .retire(retire), .csr_rdata(csr_rdata),
        .csr_rdata_valid(csr_rdata_valid), .csr_illegal(csr_illegal),
        .tohost(tohost), .tohost_wr(tohost_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, predict its effect, step one clock edge.
    task automatic drive(input logic req, input logic kill, input logic [2:0] f3,
                         input logic [11:0] addr, input logic [31:0] data,
                         input logic [4:0] idx, input logic ret);
        logic [31:0] old;
        logic [31:0] src;
        bit known, ro, f3ok, wants, fire;
        csr_req = req; csr_kill = kill; csr_funct3 = f3; csr_addr = addr;
        csr_rs1_data = data; csr_rs1_idx = idx; retire = ret;
        known = 1; ro = 1;
        if (addr == TOHOST)       begin old = m_tohost; ro = 0; end
        else if (addr == 12'hC00) old = m_cycle[31:0];
        else if (addr == 12'hC80) old = m_cycle[63:32];
        else if (addr == 12'hC02) old = m_instret[31:0];
        else if (addr == 12'hC82) old = m_instret[63:32];
        else begin old = 0; known = 0; ro = 0; end
        f3ok  = f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        src   = (f3 >= 3'd5) ? {27'b0, idx} : data;
        wants = f3ok && (f3 == 3'd1 || f3 == 3'd5 || idx != 5'd0);
        fire  = req && !kill;
        e_valid   = fire && f3ok;
        e_rdata   = e_valid ? old : 32'd0;
        e_illegal = fire && (!f3ok || !known || (ro && wants));
        e_wr      = fire && wants && (addr == TOHOST);
        if (e_wr) begin
            if (f3 == 3'd1 || f3 == 3'd5)      m_tohost = src;
            else if (f3 == 3'd2 || f3 == 3'd6) m_tohost = old | src;
            else                               m_tohost = old & ~src;
        end
        @(posedge clk);
        #1;
        m_cycle   = m_cycle + 1;
        m_instret = m_instret + (ret ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 3'd0, 12'h0, 32'h0, 5'd0, 0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(0, 0, 3'd0, 12'h0, 32'h0, 5'd0, 0);
        rst = 1'b1;
        m_cycle = 0; m_instret = 0; m_tohost = 32'h0;
        idle(10);
        n_checks++; if ({csr_rdata_valid, csr_illegal, tohost_wr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {csr_rdata_valid, csr_illegal, tohost_wr}); end
        n_checks++; if (tohost !== 32'h0) begin n_fail++; $display("FAIL reset_tohost: got %h want 0", tohost); end
        drive(1, 0, 3'd2, 12'hC00, 32'h0, 5'd0, 0);
        n_checks++; if (csr_rdata !== 32'd10) begin n_fail++; $display("FAIL reset_cycle: got %0d want 10", csr_rdata); end
        drive(1, 0, 3'd2, 12'hC02, 32'h0, 5'd0, 0);
        n_checks++; if (csr_rdata !== 32'd0 || csr_rdata_valid !== 1'b1) begin n_fail++; $display("FAIL reset_instret: got %0d/%b want 0/1", csr_rdata, csr_rdata_valid); end
    endtask

    task automatic test_tohost_rw;
        drive(1, 0, 3'd1, TOHOST, 32'd100, 5'd3, 0);
        n_checks++; if ({tohost, tohost_wr, csr_rdata, csr_rdata_valid} !== {32'd100, 1'b1, 32'd0, 1'b1}) begin n_fail++; $display("FAIL rw_tohost: got tohost=%0d wr=%b rdata=%0d v=%b want 100 1 0 1", tohost, tohost_wr, csr_rdata, csr_rdata_valid); end
        idle(1);
        n_checks++; if (tohost_wr !== 1'b0 || tohost !== 32'd100) begin n_fail++; $display("FAIL rw_pulse: got wr=%b tohost=%0d want 0 100", tohost_wr, tohost); end
    endtask

    task automatic test_rc_rs;
        // 100 & ~0x54 = 0x20
        drive(1, 0, 3'd3, TOHOST, 32'h54, 5'd9, 0);
        n_checks++; if (tohost !== 32'd32 || csr_rdata !== 32'd100 || tohost_wr !== 1'b1) begin n_fail++; $display("FAIL rc_tohost: got tohost=%0d rdata=%0d wr=%b want 32 100 1", tohost, csr_rdata, tohost_wr); end
        drive(1, 0, 3'd2, TOHOST, 32'hFFFF_FFFF, 5'd0, 0);
        n_checks++; if (tohost !== 32'd32 || tohost_wr !== 1'b0 || csr_rdata !== 32'd32) begin n_fail++; $display("FAIL rs_x0: got tohost=%0d wr=%b rdata=%0d want 32 0 32", tohost, tohost_wr, csr_rdata); end
        drive(1, 0, 3'd6, TOHOST, 32'h0, 5'd0, 0);
        n_checks++; if (tohost_wr !== 1'b0 || tohost !== 32'd32) begin n_fail++; $display("FAIL rsi_zimm0: got wr=%b tohost=%0d want 0 32", tohost_wr, tohost); end
    endtask

    task automatic test_kill;
        drive(1, 1, 3'd1, TOHOST, 32'd7, 5'd1, 0);
        n_checks++; if ({tohost, tohost_wr, csr_rdata_valid} !== {32'd32, 1'b0, 1'b0}) begin n_fail++; $display("FAIL kill: got tohost=%0d wr=%b v=%b want 32 0 0", tohost, tohost_wr, csr_rdata_valid); end
    endtask

    task automatic test_instret;
        for (int i = 0; i < 5; i++) drive(0, 0, 3'd0, 12'h0, 32'h0, 5'd0, 1);
        drive(1, 0, 3'd2, 12'hC02, 32'h0, 5'd0, 1);
        n_checks++; if (csr_rdata !== 32'd5 || csr_illegal !== 1'b0) begin n_fail++; $display("FAIL instret_same_cycle: got %0d ill=%b want 5 0", csr_rdata, csr_illegal); end
        drive(1, 0, 3'd2, 12'hC02, 32'h0, 5'd0, 0);
        n_checks++; if (csr_rdata !== 32'd6) begin n_fail++; $display("FAIL instret_after: got %0d want 6", csr_rdata); end
    endtask

    task automatic test_illegal;
        logic [31:0] c0;
        drive(1, 0, 3'd1, 12'hC00, 32'h0, 5'd4, 0);
        c0 = csr_rdata;
        n_checks++; if (csr_illegal !== 1'b1 || csr_rdata_valid !== 1'b1 || csr_rdata !== e_rdata) begin n_fail++; $display("FAIL ro_write: got ill=%b v=%b rdata=%0d want 1 1 %0d", csr_illegal, csr_rdata_valid, csr_rdata, e_rdata); end
        drive(1, 0, 3'd2, 12'hC00, 32'h0, 5'd0, 0);
        n_checks++; if (csr_rdata !== c0 + 32'd1 || csr_illegal !== 1'b0) begin n_fail++; $display("FAIL ro_unchanged: got %0d ill=%b want %0d 0", csr_rdata, csr_illegal, c0 + 32'd1); end
        drive(1, 0, 3'd2, 12'h123, 32'h0, 5'd0, 0);
        n_checks++; if (csr_rdata !== 32'd0 || csr_illegal !== 1'b1) begin n_fail++; $display("FAIL bad_addr: got %0d ill=%b want 0 1", csr_rdata, csr_illegal); end
        drive(1, 0, 3'd4, TOHOST, 32'd9, 5'd9, 0);
        n_checks++; if ({csr_illegal, csr_rdata_valid, tohost_wr, tohost} !== {1'b1, 1'b0, 1'b0, 32'd32}) begin n_fail++; $display("FAIL bad_funct3: got ill=%b v=%b wr=%b tohost=%0d want 1 0 0 32", csr_illegal, csr_rdata_valid, tohost_wr, tohost); end
    endtask

    task automatic test_back_to_back;
        drive(1, 0, 3'd5, TOHOST, 32'h0, 5'd17, 0);
        drive(1, 0, 3'd2, TOHOST, 32'h100, 5'd2, 0);
        n_checks++; if (csr_rdata !== 32'd17 || tohost !== 32'h111 || tohost_wr !== 1'b1) begin n_fail++; $display("FAIL back_to_back: got rdata=%0d tohost=%h wr=%b want 17 111 1", csr_rdata, tohost, tohost_wr); end
    endtask

    task automatic test_random;
        logic [11:0] addrs [6];
        logic [11:0] a;
        logic [4:0]  idx;
        addrs[0] = TOHOST; addrs[1] = 12'hC00; addrs[2] = 12'hC80;
        addrs[3] = 12'hC02; addrs[4] = 12'hC82; addrs[5] = 12'h000;
        for (int i = 0; i < 300; i++) begin
            a = addrs[$urandom_range(0, 5)];
            if (a == 12'h000) a = 12'($urandom);
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), 3'($urandom),
                  a, $urandom, idx, 1'($urandom));
            n_checks++;
            if ({(csr_rdata_valid ? csr_rdata : 32'd0), csr_rdata_valid, csr_illegal, tohost, tohost_wr}
                !== {e_rdata, e_valid, e_illegal, m_tohost, e_wr}) begin
                n_fail++;
                $display("FAIL random[%0d]: got rdata=%h v=%b ill=%b tohost=%h wr=%b want %h %b %b %h %b",
                         i, csr_rdata, csr_rdata_valid, csr_illegal, tohost, tohost_wr,
                         e_rdata, e_valid, e_illegal, m_tohost, e_wr);
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(1, 0, 3'd1, TOHOST, 32'd55, 5'd1, 1);
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({csr_rdata, csr_rdata_valid, csr_illegal, tohost, tohost_wr} !== 67'd0) begin n_fail++; $display("FAIL reset_async: got rdata=%h v=%b ill=%b tohost=%h wr=%b want all 0", csr_rdata, csr_rdata_valid, csr_illegal, tohost, tohost_wr); end
        @(posedge clk);
        #1 rst = 1'b1;
        m_cycle = 0; m_instret = 0; m_tohost = 32'h0;
        drive(1, 0, 3'd2, 12'hC00, 32'h0, 5'd0, 0);
        n_checks++; if (csr_rdata !== 32'd0 || tohost_wr !== 1'b0) begin n_fail++; $display("FAIL reset_restart: got cycle=%0d wr=%b want 0 0", csr_rdata, tohost_wr); end
    endtask

    initial begin
        rst = 1'b0; csr_req = 0; csr_kill = 0; csr_funct3 = 0; csr_addr = 0;
        csr_rs1_data = 0; csr_rs1_idx = 0; retire = 0;
        m_cycle = 0; m_instret = 0; m_tohost = 0;
        #1;
        test_reset();
        test_tohost_rw();
        test_rc_rs();
        test_kill();
        test_instret();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
